// File: rtl/vita_tx_msg_arbiter.sv
// vita_tx_msg_arbiter
//   Packet-aware merge of up to four 36-bit message streams onto one port.
//   Priority inputs (PRIO_MASK) beat normal ones; round-robin within each class.
//   A granted input owns the output until its EOF line transfers.
//
// Ports:
//   clk, reset         system clock, synchronous active-low reset
//   set_stb/addr/data  settings bus; address BASE holds the per-input enable mask
//   data_i, src_rdy_i  per-input lines (36 bits each: 32=SOF, 33=EOF, 35:34=occupancy)
//   dst_rdy_o          per-input ready (only the granted input can see ready)
//   data_o, src_rdy_o  merged output stream
//   dst_rdy_i          downstream ready
//   pkt_count          packets forwarded (EOF transfers), wraps
//   debug              {2'b0, state, grant, enable, last_prio, last_norm, 16'b0}
module vita_tx_msg_arbiter #(
    parameter int unsigned NUM_IN    = 4,
    parameter logic [3:0]  PRIO_MASK = 4'b0001,
    parameter logic [7:0]  BASE      = 8'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_stb,
    input  logic [7:0]            set_addr,
    input  logic [31:0]           set_data,
    input  logic [36*NUM_IN-1:0]  data_i,
    input  logic [NUM_IN-1:0]     src_rdy_i,
    output logic [NUM_IN-1:0]     dst_rdy_o,
    output logic [35:0]           data_o,
    output logic                  src_rdy_o,
    input  logic                  dst_rdy_i,
    output logic [31:0]           pkt_count,
    output logic [31:0]           debug
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPass = 2'd1
    } state_e;

    localparam logic [1:0] LastInit = 2'(NUM_IN - 1);
    localparam logic [3:0] InMask   = 4'((1 << NUM_IN) - 1);
    localparam logic [3:0] PrioMask = PRIO_MASK & InMask;

    state_e            state_q;
    logic [1:0]        grant_idx_q;
    logic [3:0]        grant_q;
    logic [NUM_IN-1:0] enable_q;
    logic [1:0]        last_prio_q;
    logic [1:0]        last_norm_q;

    logic [35:0] lane [4];
    logic [3:0]  src4;
    logic [3:0]  req;
    logic [3:0]  dst4;
    logic [2:0]  prio_pick;
    logic [2:0]  norm_pick;
    logic        pick_found;
    logic [1:0]  pick_idx;
    logic        xfer;
    logic        eof;
    logic        unused_set_data;

    assign unused_set_data = ^set_data;

    // Unused lanes (NUM_IN < 4) read as zero so the 4-wide logic below stays uniform.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        if (g < NUM_IN) begin : g_used
            assign lane[g] = data_i[36*g +: 36];
        end else begin : g_unused
            assign lane[g] = '0;
        end
    end

    // Returns {found, index}: first requester after 'last', ascending with wrap.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [2:0] pick;
        logic [2:0] pos;
        pick = 3'b000;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            pos = 3'(last) + 3'(k);
            if (pos >= 3'(NUM_IN)) begin
                pos = pos - 3'(NUM_IN);
            end
            if (!pick[2] && r[pos[1:0]]) begin
                pick = {1'b1, pos[1:0]};
            end
        end
        return pick;
    endfunction

    assign src4       = 4'(src_rdy_i);
    assign req        = src4 & 4'(enable_q);
    assign prio_pick  = rr_pick(req & PrioMask, last_prio_q);
    assign norm_pick  = rr_pick(req & ~PrioMask, last_norm_q);
    assign pick_found = prio_pick[2] | norm_pick[2];
    assign pick_idx   = prio_pick[2] ? prio_pick[1:0] : norm_pick[1:0];

    // Zero-latency passthrough while a packet owns the output.
    always_comb begin
        data_o    = '0;
        src_rdy_o = 1'b0;
        dst4      = '0;
        if (state_q == StPass) begin
            data_o            = lane[grant_idx_q];
            src_rdy_o         = src4[grant_idx_q];
            dst4[grant_idx_q] = dst_rdy_i;
        end
    end

    assign dst_rdy_o = dst4[NUM_IN-1:0];
    assign xfer      = src_rdy_o & dst_rdy_i;
    assign eof       = data_o[33];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            grant_idx_q <= '0;
            grant_q     <= '0;
            enable_q    <= '1;
            last_prio_q <= LastInit;
            last_norm_q <= LastInit;
            pkt_count   <= '0;
        end else begin
            // Enable only gates new grants; a packet in flight is never revoked.
            if (set_stb && set_addr == BASE) begin
                enable_q <= set_data[NUM_IN-1:0];
            end
            case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        grant_idx_q <= pick_idx;
                        grant_q     <= 4'b0001 << pick_idx;
                        if (prio_pick[2]) begin
                            last_prio_q <= pick_idx;
                        end else begin
                            last_norm_q <= pick_idx;
                        end
                        state_q <= StPass;
                    end
                end
                StPass: begin
                    if (xfer && eof) begin
                        pkt_count <= pkt_count + 32'd1;
                        grant_q   <= '0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign debug = {2'b00, state_q, grant_q, 4'(enable_q), last_prio_q, last_norm_q, 16'h0000};

endmodule

// File: tb/tb_vita_tx_msg_arbiter.sv
// Self-checking bench for vita_tx_msg_arbiter: per-input line queues feed a random-rate
// driver, a packet-level reference model predicts grants, and a monitor scores the output.
module tb_vita_tx_msg_arbiter;

    localparam int N = 4;
    localparam logic [3:0] PRIO = 4'b0001;

    logic          clk = 1'b0;
    logic          reset;
    logic          set_stb;
    logic [7:0]    set_addr;
    logic [31:0]   set_data;
    logic [143:0]  data_i;
    logic [3:0]    src_rdy_i;
    logic [3:0]    dst_rdy_o;
    logic [35:0]   data_o;
    logic          src_rdy_o;
    logic          dst_rdy_i;
    logic [31:0]   pkt_count;
    logic [31:0]   debug;

    always #5 clk = ~clk;

    vita_tx_msg_arbiter #(
        .NUM_IN   (4),
        .PRIO_MASK(4'b0001),
        .BASE     (8'd0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .data_i   (data_i),
        .src_rdy_i(src_rdy_i),
        .dst_rdy_o(dst_rdy_o),
        .data_o   (data_o),
        .src_rdy_o(src_rdy_o),
        .dst_rdy_i(dst_rdy_i),
        .pkt_count(pkt_count),
        .debug    (debug)
    );

    int tests = 0;
    int fails = 0;

    logic [35:0] src_q [N][$];   // lines still to be offered by the driver
    logic [35:0] exp_q [N][$];   // lines still expected at the output, per source
    int          exp_grant [$];  // predicted owner of each upcoming packet
    int          seen_grants [$];

    int rst_cycles = 0;
    int valid_pct  = 100;
    int dst_pct    = 100;
    int seq        = 0;

    // Reference model state (packet level)
    int          m_owner = -1;
    int          m_lastp = N - 1;
    int          m_lastn = N - 1;
    logic [3:0]  m_en    = 4'hF;
    logic [31:0] m_cnt   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [3:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += exp_q[i].size();
        return s;
    endfunction

    // Reference model: who owns the output, decided from the class/round-robin rules.
    initial begin
        forever begin
            logic [3:0] rq;
            int g;
            @(posedge clk);
            if (!reset) begin
                m_owner = -1;
                m_lastp = N - 1;
                m_lastn = N - 1;
                m_en    = 4'hF;
                m_cnt   = 0;
                exp_grant.delete();
            end else begin
                if (m_owner < 0) begin
                    rq = src_rdy_i & m_en;
                    if ((rq & PRIO) != 4'h0) begin
                        g = rr(rq & PRIO, m_lastp);
                        m_lastp = g;
                    end else begin
                        g = rr(rq & ~PRIO, m_lastn);
                        if (g >= 0) m_lastn = g;
                    end
                    if (g >= 0) begin
                        m_owner = g;
                        exp_grant.push_back(g);
                    end
                end else if (src_rdy_i[m_owner] && dst_rdy_i && data_i[36*m_owner+33]) begin
                    m_owner = -1;
                    m_cnt   = m_cnt + 1;
                end
                if (set_stb && set_addr == 8'd0) m_en = set_data[3:0];
            end
        end
    end

    // Driver: inputs change 1 time unit after the rising edge.
    initial begin
        logic [3:0] xfer;
        reset     = 1'b0;
        src_rdy_i = '0;
        dst_rdy_i = 1'b0;
        data_i    = '0;
        forever begin
            @(negedge clk);
            xfer = src_rdy_i & dst_rdy_o;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (xfer[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            if (rst_cycles > 0) begin
                reset     = 1'b0;
                rst_cycles--;
                src_rdy_i = '0;
                dst_rdy_i = 1'b0;
            end else begin
                reset = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (src_q[i].size() > 0) begin
                        data_i[36*i +: 36] = src_q[i][0];
                        src_rdy_i[i] = ($urandom_range(99) < valid_pct);
                    end else begin
                        data_i[36*i +: 36] = '0;
                        src_rdy_i[i] = 1'b0;
                    end
                end
                dst_rdy_i = ($urandom_range(99) < dst_pct);
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit          in_pkt = 0;
        int          cur = 0;
        int          id;
        int          g;
        logic [35:0] e;
        logic [3:0]  exp_dst;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_pkt = 0;
            end else begin
                exp_dst = (m_owner >= 0 && dst_rdy_i) ? (4'b0001 << m_owner) : 4'b0000;
                check("dst_rdy_o", dst_rdy_o, exp_dst);
                check("src_rdy_o", src_rdy_o, (m_owner >= 0) ? src_rdy_i[m_owner] : 1'b0);
                check("pkt_count", pkt_count, m_cnt);
                if (m_owner < 0) check("idle data_o", data_o, 0);
                if (src_rdy_o && dst_rdy_i) begin
                    id = int'(data_o[31:28]);
                    if (!in_pkt) begin
                        if (exp_grant.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL grant: packet from input %0d, expected no grant", id);
                        end else begin
                            g = exp_grant.pop_front();
                            check("grant", id, g);
                        end
                        seen_grants.push_back(id);
                        cur    = id;
                        in_pkt = 1;
                    end else begin
                        check("no interleave", id, cur);
                    end
                    if (id < N && exp_q[id].size() > 0) begin
                        e = exp_q[id].pop_front();
                        check("line", data_o, e);
                    end else begin
                        tests++;
                        fails++;
                        $display("FAIL line: got unexpected %0h, expected none", data_o);
                    end
                    if (data_o[33]) in_pkt = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_pkt(input int i, input int len);
        for (int l = 0; l < len; l++) begin
            logic [35:0] w;
            w[35:34] = 2'($urandom_range(3));
            w[33]    = (l == len - 1);
            w[32]    = (l == 0);
            w[31:28] = i[3:0];
            w[27:0]  = seq[27:0];
            seq++;
            src_q[i].push_back(w);
            exp_q[i].push_back(w);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (pending() > 0 && n < budget) begin
            tick(1);
            n++;
        end
        tests++;
        if (pending() > 0) begin
            fails++;
            $display("FAIL drain: %0d lines outstanding after %0d cycles, expected 0",
                     pending(), budget);
        end
        tick(3);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        tick(1);
        set_stb  = 1'b0;
    endtask

    task automatic check_order(input string name, input int exp_ord[$]);
        check({name, " count"}, seen_grants.size(), exp_ord.size());
        for (int i = 0; i < exp_ord.size() && i < seen_grants.size(); i++) begin
            check(name, seen_grants[i], exp_ord[i]);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ord[$];
        set_stb  = 1'b0;
        set_addr = '0;
        set_data = '0;
        rst_cycles = 3;
        tick(6);

        // Reset state
        check("reset dst_rdy_o", dst_rdy_o, 0);
        check("reset src_rdy_o", src_rdy_o, 0);
        check("reset pkt_count", pkt_count, 0);

        // Single 4-line packet on input 1
        add_pkt(1, 4);
        drain(50);
        check("single pkt_count", pkt_count, 1);
        check_order("single order", '{1});

        // Round-robin among normal inputs 1,2,3
        rst_cycles = 1;
        tick(4);
        seen_grants.delete();
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i < 4; i++) add_pkt(i, 2);
        end
        drain(100);
        check("rr pkt_count", pkt_count, 6);
        ord = '{1, 2, 3, 1, 2, 3};
        check_order("rr order", ord);

        // No preemption: priority input 0 waits for input 2's packet, then beats input 3
        seen_grants.delete();
        add_pkt(2, 5);
        n = 0;
        while (m_owner != 2 && n < 50) begin
            tick(1);
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL preempt setup: input 2 not granted within 50 cycles");
        end
        add_pkt(0, 2);
        add_pkt(3, 2);
        drain(100);
        ord = '{2, 0, 3};
        check_order("preempt order", ord);

        // Randomized traffic with random valid/ready
        valid_pct = 50;
        dst_pct   = 50;
        for (int p = 0; p < 40; p++) begin
            add_pkt($urandom_range(N - 1), $urandom_range(1, 6));
            tick($urandom_range(0, 8));
        end
        drain(6000);

        // Enable mask: input 1 disabled, wrong address write ignored
        valid_pct = 100;
        dst_pct   = 100;
        seen_grants.delete();
        wr(8'd1, 32'h0000_0000);
        wr(8'd0, 32'h0000_000D);
        add_pkt(1, 3);
        for (int c = 0; c < 50; c++) begin
            tick(1);
            check("disabled dst_rdy_o[1]", dst_rdy_o[1], 1'b0);
        end
        wr(8'd0, 32'h0000_000F);
        drain(50);
        check_order("reenable order", '{1});

        // Reset mid-packet
        add_pkt(0, 4);
        n = 0;
        while (exp_q[0].size() > 3 && n < 50) begin
            tick(1);
            n++;
        end
        rst_cycles = 1;
        tick(2);
        check("post-reset src_rdy_o", src_rdy_o, 0);
        check("post-reset dst_rdy_o", dst_rdy_o, 0);
        check("post-reset data_o", data_o, 0);
        check("post-reset pkt_count", pkt_count, 0);
        drain(50);
        check("post-reset resume pkt_count", pkt_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
